// File: rtl/uart_hex_seg7_ctrl.sv
// ASCII hex line parser driving active-low seven-segment digits.
// Optional inter-character timeout: define UART_HEX_SEG7_TIMEOUT_EN.
module uart_hex_seg7_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_FREQ   = 50,
    parameter int TIMEOUT_MS = 100
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [7:0]              s_tdata,
    input  logic                    s_tuser,
    input  logic                    s_tvalid,
    output logic [7*NUM_DIGITS-1:0] hex_seg,
    output logic                    line_done,
    output logic                    cmd_err,
    output logic [7:0]              err_cnt
);

    localparam int BW = 4 * NUM_DIGITS;
    localparam int SW = 7 * NUM_DIGITS;
    localparam logic [3:0] ND_CNT = 4'(NUM_DIGITS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [BW-1:0]         buf_q;
    logic [NUM_DIGITS-1:0] vld_q;
    logic [3:0]            cnt_q;

    logic       is_dig;
    logic       is_uc;
    logic       is_lc;
    logic       is_hex;
    logic       is_term;
    logic       bad;
    logic [3:0] nib;
    logic       expire;

    logic do_shift;
    logic do_err;
    logic do_commit;
    logic full;

    logic [BW-1:0] nib_ext;
    logic [SW-1:0] seg_nxt;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Character classification of the current beat
    always_comb begin
        is_dig  = (s_tdata >= 8'h30) && (s_tdata <= 8'h39);
        is_uc   = (s_tdata >= 8'h41) && (s_tdata <= 8'h46);
        is_lc   = (s_tdata >= 8'h61) && (s_tdata <= 8'h66);
        is_hex  = is_dig || is_uc || is_lc;
        is_term = (s_tdata == 8'h0D) || (s_tdata == 8'h0A);
        // parity is only fatal on non-terminators
        bad     = !is_term && (s_tuser || !is_hex);
        nib     = 4'h0;
        unique case (1'b1)
            is_dig:        nib = s_tdata[3:0];
            is_uc, is_lc:  nib = s_tdata[3:0] + 4'd9;
            default:       nib = 4'h0;
        endcase
    end

    assign full = (cnt_q == ND_CNT);

`ifdef UART_HEX_SEG7_TIMEOUT_EN
    localparam int unsigned TO_CYC = CLK_FREQ * 1000 * TIMEOUT_MS;
    localparam int TW = $clog2(TO_CYC + 1);

    logic [TW-1:0] tmr_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tmr_q <= TW'(TO_CYC - 1);
        end else if (s_tvalid || state_q == IDLE) begin
            tmr_q <= TW'(TO_CYC - 1);
        end else if (tmr_q != '0) begin
            tmr_q <= tmr_q - 1'b1;
        end
    end

    assign expire = (state_q != IDLE) && !s_tvalid && (tmr_q == '0);
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (s_tvalid && !is_term) begin
                    state_d = bad ? DISCARD : COLLECT;
                end
            end
            COLLECT: begin
                if (s_tvalid) begin
                    if (is_term) begin
                        state_d = IDLE;
                    end else if (bad || full) begin
                        state_d = DISCARD;
                    end
                end else if (expire) begin
                    state_d = IDLE;
                end
            end
            DISCARD: begin
                if ((s_tvalid && is_term) || expire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        do_shift  = 1'b0;
        do_err    = 1'b0;
        do_commit = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_tvalid && !is_term) begin
                    do_err   = bad;
                    do_shift = !bad;
                end
            end
            COLLECT: begin
                if (s_tvalid) begin
                    if (is_term) begin
                        do_commit = 1'b1;
                    end else if (bad || full) begin
                        do_err = 1'b1;
                    end else begin
                        do_shift = 1'b1;
                    end
                end else if (expire) begin
                    do_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        nib_ext      = '0;
        nib_ext[3:0] = nib;
        seg_nxt      = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (vld_q[i]) begin
                seg_nxt[7*i +: 7] = seg7(buf_q[4*i +: 4]);
            end
        end
    end

    // Buffer is always empty in IDLE, so the first digit is just a shift
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            buf_q <= '0;
            vld_q <= '0;
            cnt_q <= '0;
        end else if (do_err || do_commit) begin
            buf_q <= '0;
            vld_q <= '0;
            cnt_q <= '0;
        end else if (do_shift) begin
            buf_q <= (buf_q << 4) | nib_ext;
            vld_q <= (vld_q << 1) | NUM_DIGITS'(1);
            cnt_q <= cnt_q + 4'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hex_seg   <= '1;
            line_done <= 1'b0;
            cmd_err   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            line_done <= do_commit;
            cmd_err   <= do_err;
            if (do_commit) begin
                hex_seg <= seg_nxt;
            end
            if (do_err) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_hex_seg7_ctrl.sv
// Scoreboard bench for uart_hex_seg7_ctrl (NUM_DIGITS=4).
// Timeout case runs only when UART_HEX_SEG7_TIMEOUT_EN is defined.
module tb_uart_hex_seg7_ctrl;

    localparam int ND = 4;

    logic          aclk;
    logic          aresetn;
    logic [7:0]    s_tdata;
    logic          s_tuser;
    logic          s_tvalid;
    logic [7*ND-1:0] hex_seg;
    logic          line_done;
    logic          cmd_err;
    logic [7:0]    err_cnt;

    typedef struct {
        bit          is_err;
        logic [27:0] seg;
        logic [7:0]  ecnt;
    } exp_t;

    exp_t sb[$];

    int n_chk = 0;
    int n_err = 0;

    logic [27:0] cur_seg;
    logic [7:0]  ecnt_m;
    int          err_total;

    uart_hex_seg7_ctrl #(
        .NUM_DIGITS(ND),
        .CLK_FREQ  (1),
        .TIMEOUT_MS(1)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_tdata  (s_tdata),
        .s_tuser  (s_tuser),
        .s_tvalid (s_tvalid),
        .hex_seg  (hex_seg),
        .line_done(line_done),
        .cmd_err  (cmd_err),
        .err_cnt  (err_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per output pulse
    always @(negedge aclk) begin
        if (aresetn) begin
            if (line_done && cmd_err) begin
                chk("exclusive_pulses", 64'(1), 64'(0));
            end else if (line_done || cmd_err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {62'd0, line_done, cmd_err}, 64'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pulse_kind", 64'(cmd_err), 64'(e.is_err));
                    chk("hex_seg", 64'(hex_seg), 64'(e.seg));
                    chk("err_cnt", 64'(err_cnt), 64'(e.ecnt));
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic tu);
        s_tdata  = b;
        s_tuser  = tu;
        s_tvalid = 1'b1;
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], 1'b0);
        end
    endtask

    task automatic exp_commit(input logic [27:0] seg);
        exp_t e;
        cur_seg  = seg;
        e.is_err = 1'b0;
        e.seg    = seg;
        e.ecnt   = ecnt_m;
        sb.push_back(e);
    endtask

    task automatic exp_error();
        exp_t e;
        ecnt_m    = ecnt_m + 8'd1;
        err_total = err_total + 1;
        e.is_err  = 1'b1;
        e.seg     = cur_seg;
        e.ecnt    = ecnt_m;
        sb.push_back(e);
    endtask

    task automatic drain(input string nm, input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(posedge aclk);
            k++;
        end
        #1;
        chk(nm, 64'(sb.size()), 64'(0));
        sb.delete();
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn   = 1'b0;
        s_tdata   = 8'h00;
        s_tuser   = 1'b0;
        s_tvalid  = 1'b0;
        cur_seg   = '1;
        ecnt_m    = 8'd0;
        err_total = 0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_hex_seg", 64'(hex_seg), 64'(28'hFFFFFFF));
        chk("rst_line_done", 64'(line_done), 64'(0));
        chk("rst_cmd_err", 64'(cmd_err), 64'(0));
        chk("rst_err_cnt", 64'(err_cnt), 64'(0));
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Back-to-back lines, then an empty CR LF
        exp_commit({7'h79, 7'h24, 7'h08, 7'h0E});
        send_str("12AF\r");
        exp_commit({7'h7F, 7'h7F, 7'h7F, 7'h78});
        send_str("7\n");
        send_str("\r\n");
        drain("drain_basic", 10);

        exp_commit({7'h08, 7'h03, 7'h46, 7'h21});
        send_str("abcd\r");
        exp_commit({7'h7F, 7'h06, 7'h06, 7'h40});
        send_str("Ee0\r");
        drain("drain_case", 10);

        exp_error();
        send_str("12G4\r");
        exp_error();
        send_str("12345\r");
        exp_commit({7'h7F, 7'h7F, 7'h7F, 7'h10});
        send_str("9\r");
        drain("drain_errs", 10);

        exp_error();
        send(8'h33, 1'b1);
        send_str("\r");
        exp_error();
        send_str("xyz\n");
        drain("drain_parity", 10);

        while (err_total < 256) begin
            exp_error();
            send_str("q\r");
        end
        drain("drain_wrap", 10);
        chk("err_cnt_wrap", 64'(err_cnt), 64'(0));
        chk("disp_after_wrap", 64'(hex_seg),
            64'({7'h7F, 7'h7F, 7'h7F, 7'h10}));

        // Asynchronous reset in the middle of a line
        send_str("12");
        #3;
        aresetn = 1'b0;
        #1;
        chk("midrst_hex_seg", 64'(hex_seg), 64'(28'hFFFFFFF));
        chk("midrst_err_cnt", 64'(err_cnt), 64'(0));
        @(negedge aclk);
        aresetn = 1'b1;
        cur_seg = '1;
        ecnt_m  = 8'd0;
        @(posedge aclk);
        #1;
        exp_commit({7'h7F, 7'h7F, 7'h7F, 7'h19});
        send_str("4\r");
        drain("drain_midrst", 10);

`ifdef UART_HEX_SEG7_TIMEOUT_EN
        exp_error();
        send_str("5");
        drain("drain_timeout", 1200);
        exp_commit({7'h7F, 7'h7F, 7'h7F, 7'h02});
        send_str("6\r");
        drain("drain_after_to", 10);
`endif

        repeat (3) @(posedge aclk);
        #1;
        chk("final_lines", 64'(line_done), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
